fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Multi-cycle single-precision divider for the FPU; computes a/b as a * (1/b). It is the consumer stage of the combinational fp_recip reciprocal unit, instantiating it only for b's normalized significand. It then multiplies, renormalizes, packs the result and merges exception flags. It sits behind the FPU issue logic on a valid/ready handshake with one operation in flight.

Parameters:
EXP, 8, exponent field width
FRAC, 23, fraction field width
BIAS, 127, exponent bias

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operands presented
in_ready  output  1  block can accept; high only in IDLE
a_bits  input  32  dividend, IEEE-754 single
b_bits  input  32  divisor, IEEE-754 single
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result_bits  output  32  quotient
except_flags  output  5  bit positions given by F_INVALID, F_DIVIDE_BY_ZERO, F_OVERFLOW, F_UNDERFLOW, F_INEXACT from macros.vh

Behaviour:
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, result_bits=0, except_flags=0.
  - rst asserted in any state, including mid-operation, discards the operation and gives the same values on the next cycle.
  - No stale result may appear after reset.
- FSM states: IDLE -> NORM -> RECIP -> MUL -> PACK -> DONE -> IDLE.
  - IDLE: in_valid&&in_ready at edge E0 captures a_bits/b_bits and moves to NORM.
  - NORM, RECIP, MUL and PACK each last exactly one cycle, special cases included.
  - out_valid is high from after edge E0+4. Latency is fixed at 4 cycles.
  - DONE: result_bits, except_flags and out_valid are held stable until out_valid&&out_ready, then return to IDLE. in_ready is 0 outside IDLE.
  - in_valid outside IDLE is ignored.
- Back-to-back operations: the earliest next accept is the cycle after the DONE handshake.
- NORM:
  - Split sign, exponent and fraction; classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormals are normalized by leading-zero count. Significand m = {1,frac<<lz}; unbiased exponent = 1-BIAS-lz.
  - Normal operands: unbiased exponent = exp-BIAS.
  - Register sign = sa^sb.
- RECIP: drive fp_recip with {1'b0, 8'd127, mb[22:0]}; register its output. Its exponent re is 126 or 127, so its flags are ignored. Register mr = {1,recip_frac} and radj = re-127 (value -1 or 0).
- MUL:
  - P = ma*mr, 24x24 -> 48 bits, unsigned, registered.
  - Exponent sum E = ea_u - eb_u + radj + BIAS, held in a signed integer of at least 11 bits.
- PACK:
  - If P[47]: frac = P[46:24], E+1. Otherwise frac = P[45:23]. Rounding is truncation.
  - E>=255 -> signed inf, flags OVERFLOW|INEXACT.
  - E<=0 -> signed zero, flags UNDERFLOW|INEXACT. No subnormal outputs.
  - Otherwise {sign, E[7:0], frac} with flag INEXACT.
- Special cases (override arithmetic, checked in priority order, no INEXACT):
  - Either operand NaN -> 0x7FC00000, INVALID.
  - 0/0 or inf/inf -> 0x7FC00000, INVALID.
  - Finite nonzero / 0 -> signed inf, DIVIDE_BY_ZERO.
  - inf/finite -> signed inf, no flags.
  - 0/nonzero finite, finite/inf -> signed zero, no flags.
- Accuracy: non-special, in-range results are within 2 ulp of the correctly rounded quotient.

Decomposition:
- fp_pkg:
  - Field widths, BIAS, QNAN=0x7FC00000, POS_INF=0x7F800000.
  - FSM state encoding (localparams).
  - Operand class encoding (ZERO, SUB, NORM, INF, NAN).
  - Flag bit positions from macros.vh.
- Instances:
  - One existing fp_recip.
  - New sub-module fp_lzc24: combinational 24-bit leading-zero counter, 5-bit output. Two instances, one per operand.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> result within 2 ulp of 0x40400000, flags=INEXACT, out_valid exactly 4 cycles after accept. Subnormal divisor: a=0x00800000, b=0x00000001 -> within 2 ulp of 0x4B000000.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000, DIVIDE_BY_ZERO.
  - 0xBF800000/0 -> 0xFF800000.
  - 0/0 and 0x7F800000/0x7F800000 -> 0x7FC00000, INVALID.
  - 0x7FC00001/1.0 -> 0x7FC00000, INVALID.
  - 1.0/0xFF800000 -> 0x80000000, no flags.
- Range: 0x7F000000/0x3E800000 -> 0x7F800000, OVERFLOW|INEXACT. 0x00800000/0x41000000 -> 0x00000000, UNDERFLOW|INEXACT.
- Backpressure: out_ready low 10 cycles after out_valid -> result/flags unchanged, in_ready=0, in_valid pulses ignored. A new op accepted after release completes correctly.
- Reset in MUL: assert rst one cycle -> next cycle in_ready=1, out_valid=0, result_bits=0, except_flags=0. No result appears for the aborted op.
- Streaming: 20 random normal pairs with out_ready tied high -> each accepted the cycle after the previous DONE handshake. All results match the reference model within 2 ulp.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants for the single-precision divide path: field widths, special encodings,
// FSM state codes, operand class codes and exception-flag bit positions.
// Pure definitions; no logic, no latency, no handshake.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIG_W    = FRAC_W + 1;
    localparam int EXP_BIAS = 127;
    localparam int NFLAGS   = 5;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NORM  = 3'd1;
    localparam logic [2:0] S_RECIP = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_PACK  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Operand class encoding
    localparam logic [2:0] C_ZERO = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_NORM = 3'd2;
    localparam logic [2:0] C_INF  = 3'd3;
    localparam logic [2:0] C_NAN  = 3'd4;

    // Exception flag bit positions (IEEE order, invalid in the MSB)
    localparam int F_INEXACT        = 0;
    localparam int F_UNDERFLOW      = 1;
    localparam int F_OVERFLOW       = 2;
    localparam int F_DIVIDE_BY_ZERO = 3;
    localparam int F_INVALID        = 4;

    function automatic logic [2:0] classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == '0)
            return (f == '0) ? C_ZERO : C_SUB;
        if (e == '1)
            return (f == '0) ? C_INF : C_NAN;
        return C_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter over a 24-bit significand; in_dat -> lz_cnt (24 when in_dat is zero).
// Purely combinational, zero latency.
// No handshake; output follows input.
module fp_lzc24 (
    input  logic [23:0] in_dat,
    output logic [4:0]  lz_cnt
);

    logic found;

    always_comb begin
        lz_cnt = 5'd24;
        found  = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && in_dat[i]) begin
                lz_cnt = 5'(23 - i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_recip.sv
// Single-precision reciprocal 1/x: in_bits -> out_bits plus out_flags (NV, DZ, OF, UF, NX).
// Purely combinational, zero latency; significand quotient is rounded to nearest.
// No handshake; output follows input. Subnormal inputs overflow to signed infinity.
module fp_recip
    import fp_pkg::*;
(
    input  logic [31:0]       in_bits,
    output logic [31:0]       out_bits,
    output logic [NFLAGS-1:0] out_flags
);

    logic              sgn;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic [SIG_W-1:0]  sig;
    logic [47:0]       num;
    logic [47:0]       quo;
    logic [9:0]        re;
    logic              unused_quo;

    always_comb begin
        sgn = in_bits[31];
        e   = in_bits[30:23];
        f   = in_bits[22:0];
        sig = {1'b1, f};
        // 2^47 / sig lands in (2^23, 2^24) for sig > 2^23; adding sig/2 rounds to nearest
        num = 48'h8000_0000_0000 + {25'd0, sig[23:1]};
        quo = num / {24'd0, sig};
        // 1/1.0 keeps the exponent mirror at 254; any other significand drops one binade
        re  = ((f == '0) ? 10'd254 : 10'd253) - {2'd0, e};

        out_bits  = '0;
        out_flags = '0;
        if (e == '1) begin
            if (f != '0) begin
                out_bits             = QNAN;
                out_flags[F_INVALID] = ~f[22];
            end else begin
                out_bits = {sgn, 31'd0};
            end
        end else if (e == '0) begin
            out_bits = POS_INF | {sgn, 31'd0};
            if (f == '0) begin
                out_flags[F_DIVIDE_BY_ZERO] = 1'b1;
            end else begin
                out_flags[F_OVERFLOW] = 1'b1;
                out_flags[F_INEXACT]  = 1'b1;
            end
        end else if (re[9] || re == 10'd0) begin
            out_bits               = {sgn, 31'd0};
            out_flags[F_UNDERFLOW] = 1'b1;
            out_flags[F_INEXACT]   = 1'b1;
        end else if (f == '0) begin
            out_bits = {sgn, re[7:0], 23'd0};
        end else begin
            out_bits             = {sgn, re[7:0], quo[22:0]};
            out_flags[F_INEXACT] = 1'b1;
        end
    end

    assign unused_quo = ^{quo[47:23], re[8]};

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider a/b = a * (1/b); ports: clk, rst, in_valid/in_ready + a_bits/b_bits,
// out_valid/out_ready + result_bits/except_flags. Latency 4 cycles accept-to-out_valid, one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, in_valid ignored elsewhere.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP  = EXP_W,
    parameter int FRAC = FRAC_W,
    parameter int BIAS = EXP_BIAS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a_bits,
    input  logic [31:0]       b_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result_bits,
    output logic [NFLAGS-1:0] except_flags
);

    localparam logic signed [11:0] BIAS_S = 12'(BIAS);

    logic [2:0]         state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic [SIG_W-1:0]   ma_q, ma_d, mb_q, mb_d, mr_q, mr_d;
    logic signed [11:0] ea_q, ea_d, eb_q, eb_d, radj_q, radj_d, esum_q, esum_d;
    logic               spec_vld_q, spec_vld_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic [NFLAGS-1:0]  spec_flg_q, spec_flg_d;
    logic [47:0]        prod_q, prod_d;
    logic [31:0]        res_q, res_d;
    logic [NFLAGS-1:0]  flg_q, flg_d;

    logic [EXP-1:0]     exp_a, exp_b;
    logic [FRAC-1:0]    frac_a, frac_b;
    logic [2:0]         cls_a, cls_b;
    logic [4:0]         lz_a, lz_b;
    logic [SIG_W-1:0]   sh_a, sh_b;
    logic [31:0]        recip_in, recip_out;
    logic [NFLAGS-1:0]  recip_flg;
    logic signed [11:0] e_fin;
    logic [FRAC-1:0]    frac_p;
    logic               unused_bits;

    assign exp_a  = a_q[FRAC+EXP-1:FRAC];
    assign exp_b  = b_q[FRAC+EXP-1:FRAC];
    assign frac_a = a_q[FRAC-1:0];
    assign frac_b = b_q[FRAC-1:0];
    assign cls_a  = classify(exp_a, frac_a);
    assign cls_b  = classify(exp_b, frac_b);

    fp_lzc24 u_lzc_a (.in_dat({1'b0, frac_a}), .lz_cnt(lz_a));
    fp_lzc24 u_lzc_b (.in_dat({1'b0, frac_b}), .lz_cnt(lz_b));

    // Shifting the leading one up to bit 23 leaves the normalized fraction in the low bits
    assign sh_a = {1'b0, frac_a} << lz_a;
    assign sh_b = {1'b0, frac_b} << lz_b;

    // Only b's significand goes through the reciprocal, scaled into [1,2) so 1/m is in (0.5,1]
    assign recip_in = {1'b0, EXP'(BIAS), mb_q[FRAC-1:0]};

    fp_recip u_recip (.in_bits(recip_in), .out_bits(recip_out), .out_flags(recip_flg));

    // Product lies in [1,4); a set MSB means one extra binade
    assign e_fin  = prod_q[47] ? esum_q + 12'sd1 : esum_q;
    assign frac_p = prod_q[47] ? prod_q[46:24] : prod_q[45:23];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        mr_d       = mr_q;
        radj_d     = radj_q;
        esum_d     = esum_q;
        spec_vld_d = spec_vld_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        prod_d     = prod_q;
        res_d      = res_q;
        flg_d      = flg_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a_bits;
                    b_d     = b_bits;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                sign_d = a_q[31] ^ b_q[31];
                if (cls_a == C_SUB) begin
                    ma_d = {1'b1, sh_a[FRAC-1:0]};
                    ea_d = 12'sd1 - BIAS_S - $signed(12'(lz_a));
                end else begin
                    ma_d = {1'b1, frac_a};
                    ea_d = $signed(12'(exp_a)) - BIAS_S;
                end
                if (cls_b == C_SUB) begin
                    mb_d = {1'b1, sh_b[FRAC-1:0]};
                    eb_d = 12'sd1 - BIAS_S - $signed(12'(lz_b));
                end else begin
                    mb_d = {1'b1, frac_b};
                    eb_d = $signed(12'(exp_b)) - BIAS_S;
                end

                // Special operands resolved now; PACK picks these over the arithmetic
                spec_vld_d = 1'b1;
                spec_res_d = '0;
                spec_flg_d = '0;
                if (cls_a == C_NAN || cls_b == C_NAN) begin
                    spec_res_d            = QNAN;
                    spec_flg_d[F_INVALID] = 1'b1;
                end else if ((cls_a == C_ZERO && cls_b == C_ZERO) ||
                             (cls_a == C_INF && cls_b == C_INF)) begin
                    spec_res_d            = QNAN;
                    spec_flg_d[F_INVALID] = 1'b1;
                end else if (cls_b == C_ZERO && cls_a != C_INF) begin
                    spec_res_d                   = POS_INF | {sign_d, 31'd0};
                    spec_flg_d[F_DIVIDE_BY_ZERO] = 1'b1;
                end else if (cls_a == C_INF) begin
                    spec_res_d = POS_INF | {sign_d, 31'd0};
                end else if (cls_a == C_ZERO || cls_b == C_INF) begin
                    spec_res_d = {sign_d, 31'd0};
                end else begin
                    spec_vld_d = 1'b0;
                end
                state_d = S_RECIP;
            end
            S_RECIP: begin
                mr_d    = {1'b1, recip_out[FRAC-1:0]};
                radj_d  = (recip_out[30:23] == 8'd127) ? 12'sd0 : -12'sd1;
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = 48'(ma_q) * 48'(mr_q);
                esum_d  = ea_q - eb_q + radj_q + BIAS_S;
                state_d = S_PACK;
            end
            S_PACK: begin
                flg_d = '0;
                if (spec_vld_q) begin
                    res_d = spec_res_q;
                    flg_d = spec_flg_q;
                end else if (e_fin >= 12'sd255) begin
                    res_d             = POS_INF | {sign_q, 31'd0};
                    flg_d[F_OVERFLOW] = 1'b1;
                    flg_d[F_INEXACT]  = 1'b1;
                end else if (e_fin <= 12'sd0) begin
                    res_d              = {sign_q, 31'd0};
                    flg_d[F_UNDERFLOW] = 1'b1;
                    flg_d[F_INEXACT]   = 1'b1;
                end else begin
                    res_d            = {sign_q, e_fin[7:0], frac_p};
                    flg_d[F_INEXACT] = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            ea_q       <= '0;
            eb_q       <= '0;
            mr_q       <= '0;
            radj_q     <= '0;
            esum_q     <= '0;
            spec_vld_q <= 1'b0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            prod_q     <= '0;
            res_q      <= '0;
            flg_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            mr_q       <= mr_d;
            radj_q     <= radj_d;
            esum_q     <= esum_d;
            spec_vld_q <= spec_vld_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            prod_q     <= prod_d;
            res_q      <= res_d;
            flg_q      <= flg_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign result_bits  = res_q;
    assign except_flags = flg_q;

    // Reciprocal flags are meaningless for a significand-only input; low product bits fall below truncation
    assign unused_bits = ^{recip_flg, recip_out[31], prod_q[22:0], mb_q[SIG_W-1]};

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed + random bench for fp_div_seq with an expectation queue filled at accept time.
// Expected values come from constants or an integer division model of the IEEE quotient.
// Checks latency, hold under backpressure, reset abort and streaming accept timing.
module tb_fp_div_seq;

    localparam logic [4:0] NX = 5'h01;
    localparam logic [4:0] UF = 5'h02;
    localparam logic [4:0] OF = 5'h04;
    localparam logic [4:0] DZ = 5'h08;
    localparam logic [4:0] NV = 5'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_bits;
    logic [31:0] b_bits;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_bits;
    logic [4:0]  except_flags;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_bits      (a_bits),
        .b_bits      (b_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_bits (result_bits),
        .except_flags(except_flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          tol;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int ulp_dist(input logic [31:0] x, input logic [31:0] y);
        int d;
        if (x[31] != y[31]) return 1 << 20;
        d = int'({1'b0, x[30:0]}) - int'({1'b0, y[30:0]});
        return (d < 0) ? -d : d;
    endfunction

    function automatic void unpack_op(input logic [31:0] v, output logic [23:0] m, output int e);
        if (v[30:23] == 8'd0) begin
            m = {1'b0, v[22:0]};
            e = -126;
            for (int k = 0; k < 24 && !m[23]; k++) begin
                m = m << 1;
                e = e - 1;
            end
        end else begin
            m = {1'b1, v[22:0]};
            e = int'(v[30:23]) - 127;
        end
    endfunction

    // Round-to-nearest quotient for finite, nonzero operands with an in-range result
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [23:0] ma, mb;
        int          ea, eb, e;
        logic [63:0] q;
        unpack_op(a, ma, ea);
        unpack_op(b, mb, eb);
        if (ma >= mb) begin
            q = ({40'd0, ma} << 24) / {40'd0, mb};
            e = ea - eb + 127;
        end else begin
            q = ({40'd0, ma} << 25) / {40'd0, mb};
            e = ea - eb + 126;
        end
        return {a[31] ^ b[31], 8'(e), q[23:1]} + {31'd0, q[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int tol);
        checks++;
        assert ((ulp_dist(obs, expv) <= tol) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (+-%0d ulp)", tag, obs, expv, tol);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [4:0] ef, input int tol);
        a_bits   = a;
        b_bits   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back('{er, ef, tol});
    endtask

    task automatic collect(input string tag, input int hold);
        int          lat;
        logic        ok;
        logic [31:0] r0;
        logic [4:0]  f0;
        exp_t        e;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        if (hold > 0) begin
            r0 = result_bits;
            f0 = except_flags;
            ok = 1'b1;
            for (int k = 0; k < hold; k++) begin
                a_bits   = 32'h3F80_0000;
                b_bits   = 32'h4000_0000;
                in_valid = k[0];
                @(posedge clk);
                #1;
                if (result_bits !== r0 || except_flags !== f0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                    ok = 1'b0;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
        end
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{32'hDEAD_BEEF, 5'h1F, 0};
        if (e.tol == 0) chk({tag, "_result"}, result_bits, e.res);
        else chk_near({tag, "_result"}, result_bits, e.res, e.tol);
        chk({tag, "_flags"}, 32'(except_flags), 32'(e.flg));
        @(posedge clk);
        #1;
        chk({tag, "_after_handshake"}, 32'({in_ready, out_valid}), 32'h2);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_bits    = '0;
        b_bits    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result_bits, 32'd0);
        chk("reset_flags", 32'(except_flags), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, NX, 2);
        collect("six_by_two", 0);
        issue(32'h0080_0000, 32'h0000_0001, 32'h4B00_0000, NX, 2);
        collect("sub_divisor", 0);

        issue(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, DZ, 0);
        collect("one_by_zero", 0);
        issue(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, DZ, 0);
        collect("neg_by_zero", 0);
        issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, NV, 0);
        collect("zero_by_zero", 0);
        issue(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, NV, 0);
        collect("inf_by_inf", 0);
        issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, NV, 0);
        collect("nan_operand", 0);
        issue(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 5'h00, 0);
        collect("one_by_neginf", 0);
        issue(32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 5'h00, 0);
        collect("inf_by_two", 0);

        issue(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, OF | NX, 0);
        collect("overflow", 0);
        issue(32'h0080_0000, 32'h4100_0000, 32'h0000_0000, UF | NX, 0);
        collect("underflow", 0);

        out_ready = 1'b0;
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, NX, 2);
        collect("backpressure", 10);
        issue(32'h4120_0000, 32'h4080_0000, 32'h4020_0000, NX, 2);
        collect("after_release", 0);

        // Abort an operation while it is in MUL
        a_bits   = 32'h40C0_0000;
        b_bits   = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result_bits, 32'd0);
        chk("abort_flags", 32'(except_flags), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 20; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom_range(0, 32'h1F_FFFF))};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom & 32'h7F_FFFF)};
            issue(ra, rb, ref_div(ra, rb), NX, 2);
            collect("stream", 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
